// File: rtl/iob_vga_scan_if.sv
// Pixel/sync bundle between the VGA scan generator and its neighbours.
//   master : the scan generator (drives coordinates, sync, colour to DAC)
//   slave  : renderer/board side (supplies vga_rgb_in, observes the rest)
// Optional VGA_TEST_PATTERN_EN adds vga_pattern_sel (slave -> master).
interface iob_vga_scan_if;
  logic [9:0]  vga_pixel_x;
  logic [9:0]  vga_pixel_y;
  logic [11:0] vga_rgb_in;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_active;
  logic        vga_frame_start;
`ifdef VGA_TEST_PATTERN_EN
  logic        vga_pattern_sel;

  modport master (
    output vga_pixel_x, vga_pixel_y, vga_hsync, vga_vsync,
           vga_r, vga_g, vga_b, vga_active, vga_frame_start,
    input  vga_rgb_in, vga_pattern_sel
  );
  modport slave (
    input  vga_pixel_x, vga_pixel_y, vga_hsync, vga_vsync,
           vga_r, vga_g, vga_b, vga_active, vga_frame_start,
    output vga_rgb_in, vga_pattern_sel
  );
`else
  modport master (
    output vga_pixel_x, vga_pixel_y, vga_hsync, vga_vsync,
           vga_r, vga_g, vga_b, vga_active, vga_frame_start,
    input  vga_rgb_in
  );
  modport slave (
    input  vga_pixel_x, vga_pixel_y, vga_hsync, vga_vsync,
           vga_r, vga_g, vga_b, vga_active, vga_frame_start,
    output vga_rgb_in
  );
`endif
endinterface

// File: rtl/iob_vga_scan.sv
// VGA raster scan generator.
// Divides clk into a pixel tick, runs horizontal/vertical counters, presents
// the current visible coordinate to the renderer and registers blanked RGB
// plus hsync/vsync one pixel tick later so all DAC-side outputs stay aligned.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : iob_vga_scan_if.master (pixel_x/y out, rgb_in in, sync/colour/
//          active/frame_start out)
// Optional feature macro: VGA_TEST_PATTERN_EN (colour-bar source selected by
// bus.vga_pattern_sel, sampled on the pixel tick).
module iob_vga_scan #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  iob_vga_scan_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // A divider of 1 still needs a 1-bit register; it simply never leaves 0.
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_ACT_L = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_L = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             act_q, act_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             fs_q, fs_d;

  logic             pix_tick_c;
  logic             in_act_c;
  logic [11:0]      src_rgb_c;

  assign pix_tick_c = (div_q == DIV_LAST);
  assign in_act_c   = (h_q < H_ACT_L) && (v_q < V_ACT_L);

  // Colour source for the current pixel period
`ifdef VGA_TEST_PATTERN_EN
  assign src_rgb_c = bus.vga_pattern_sel ?
                     {{4{h_q[8]}}, {4{h_q[7]}}, {4{h_q[6]}}} : bus.vga_rgb_in;
`else
  assign src_rgb_c = bus.vga_rgb_in;
`endif

  // Next-state: divider, counters and output stage (all advance on pix_tick)
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    act_d = act_q;
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    fs_d  = 1'b0;
    if (pix_tick_c) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      act_d = in_act_c;
      rgb_d = in_act_c ? src_rgb_c : 12'h000;
      hs_d  = ((h_q >= HS_BEG) && (h_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_d  = ((v_q >= VS_BEG) && (v_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
      fs_d  = (h_q == H_LAST) && (v_q == V_LAST);
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      act_q <= 1'b0;
      rgb_q <= '0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      act_q <= act_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
    end
  end

  // Renderer coordinates are combinational and parked at 0 in blanking
  assign bus.vga_pixel_x     = (h_q < H_ACT_L) ? h_q : 10'd0;
  assign bus.vga_pixel_y     = (v_q < V_ACT_L) ? v_q : 10'd0;
  assign bus.vga_hsync       = hs_q;
  assign bus.vga_vsync       = vs_q;
  assign bus.vga_r           = rgb_q[11:8];
  assign bus.vga_g           = rgb_q[7:4];
  assign bus.vga_b           = rgb_q[3:0];
  assign bus.vga_active      = act_q;
  assign bus.vga_frame_start = fs_q;

endmodule

// File: tb/tb_iob_vga_scan.sv
// Bench for iob_vga_scan with a shrunken raster: CLK_DIV=4, H 8/2/3/2
// (total 15), V 4/1/2/1 (total 8), active-low sync. The renderer model
// returns {y[3:0], x[3:0], 4'hA} so every visible pixel's colour is unique.
module tb_iob_vga_scan;

  localparam int unsigned NV = 19;

  typedef struct {
    int          e;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        act;
    logic [11:0] rgb;
    logic        fs;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl [NV];

  iob_vga_scan_if bus ();

  iob_vga_scan #(
    .CLK_DIV (4),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.vga_rgb_in = {bus.vga_pixel_y[3:0], bus.vga_pixel_x[3:0], 4'hA};
`ifdef VGA_TEST_PATTERN_EN
  assign bus.vga_pattern_sel = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"},   32'(bus.vga_pixel_x), 32'd0);
    chk({tag, "_y"},   32'(bus.vga_pixel_y), 32'd0);
    chk({tag, "_hs"},  32'(bus.vga_hsync), 32'd1);
    chk({tag, "_vs"},  32'(bus.vga_vsync), 32'd1);
    chk({tag, "_act"}, 32'(bus.vga_active), 32'd0);
    chk({tag, "_rgb"}, 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'd0);
    chk({tag, "_fs"},  32'(bus.vga_frame_start), 32'd0);
  endtask

  // Runs 960 clks (two frames) from a reset release, checking table points
  // and accumulating line/frame statistics.
  task automatic run_scan(input string tag);
    int idx = 0;
    int hs_low = 0;
    int act_cnt = 0;
    int fs_cnt = 0;
    int blank_bad = 0;
    for (int e = 1; e <= 960; e++) begin
      @(posedge clk);
      #1;
      while (idx < int'(NV) && tbl[idx].e == e) begin
        string n;
        n = $sformatf("%s_e%0d", tag, e);
        chk({n, "_x"},   32'(bus.vga_pixel_x), 32'(tbl[idx].x));
        chk({n, "_y"},   32'(bus.vga_pixel_y), 32'(tbl[idx].y));
        chk({n, "_hs"},  32'(bus.vga_hsync), 32'(tbl[idx].hs));
        chk({n, "_vs"},  32'(bus.vga_vsync), 32'(tbl[idx].vs));
        chk({n, "_act"}, 32'(bus.vga_active), 32'(tbl[idx].act));
        chk({n, "_rgb"}, 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(tbl[idx].rgb));
        chk({n, "_fs"},  32'(bus.vga_frame_start), 32'(tbl[idx].fs));
        idx++;
      end
      if (e <= 60 && bus.vga_hsync == 1'b0) hs_low++;
      if (e > 480) begin
        if (bus.vga_active) act_cnt++;
        if (bus.vga_frame_start) fs_cnt++;
      end
      if (!bus.vga_active && {bus.vga_r, bus.vga_g, bus.vga_b} != 12'h000) blank_bad++;
    end
    chk({tag, "_table_done"}, 32'(idx), 32'(NV));
    chk({tag, "_hsync_low_clks"}, 32'(hs_low), 32'd12);
    chk({tag, "_active_clks"}, 32'(act_cnt), 32'd128);
    chk({tag, "_frame_pulses"}, 32'(fs_cnt), 32'd1);
    chk({tag, "_blank_rgb_nonzero"}, 32'(blank_bad), 32'd0);
  endtask

  initial begin
    //            e    x      y      hs    vs    act   rgb      fs
    tbl[0]  = '{  3, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    tbl[1]  = '{  4, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b0};
    tbl[2]  = '{  7, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b0};
    tbl[3]  = '{  8, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 12'h01A, 1'b0};
    tbl[4]  = '{ 32, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 12'h07A, 1'b0};
    tbl[5]  = '{ 36, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    tbl[6]  = '{ 44, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0};
    tbl[7]  = '{ 52, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0};
    tbl[8]  = '{ 56, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    tbl[9]  = '{ 60, 10'd0, 10'd1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    tbl[10] = '{ 64, 10'd1, 10'd1, 1'b1, 1'b1, 1'b1, 12'h10A, 1'b0};
    tbl[11] = '{208, 10'd7, 10'd3, 1'b1, 1'b1, 1'b1, 12'h36A, 1'b0};
    tbl[12] = '{304, 10'd1, 10'd0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0};
    tbl[13] = '{420, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0};
    tbl[14] = '{424, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    tbl[15] = '{479, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    tbl[16] = '{480, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1};
    tbl[17] = '{481, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0};
    tbl[18] = '{484, 10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 12'h00A, 1'b0};

    // Power-on reset, held across several edges
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    @(negedge clk);
    rst = 1'b1;
    run_scan("run1");

    // Mid-frame reset while a visible pixel is on the outputs
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_act", 32'(bus.vga_active), 32'd1);
    chk("pre_rst_x", 32'(bus.vga_pixel_x), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rst = 1'b1;
    run_scan("run2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
